instruction_prefetch: RTL and testbench
=======================================

// Module: instruction_prefetch
// PURPOSE
//  Parametrised fetch front-end; next generation of the single-register PC/fetch path.
//  Issues in-order imem requests, keeps up to MAX_OUTSTANDING in flight, buffers responses in a
//  QUEUE_DEPTH prefetch queue, hands {pc,instr} to decode via valid/ready.
//  Supports branch/jump redirect with flush and discard of stale in-flight responses.
// PARAMETERS
//  ADDR_WIDTH      32  PC / imem address width (bits)
//  INSTR_WIDTH     32  instruction width (bits)
//  QUEUE_DEPTH     4   prefetch queue entries; power of 2, >=2
//  MAX_OUTSTANDING 2   max accepted-but-unanswered imem requests; 1..QUEUE_DEPTH
//  RESET_VECTOR    0   first fetch address; 4-byte aligned
// PORTS
//  clk             in   1            clock, rising edge
//  rst             in   1            asynchronous, active-low reset
//  imem_req_valid  out  1            request valid
//  imem_req_ready  in   1            memory accepts request
//  imem_req_addr   out  ADDR_WIDTH   request byte address
//  imem_rsp_valid  in   1            response valid; in order, one per accepted request, latency>=1
//  imem_rsp_data   in   INSTR_WIDTH  response instruction
//  redirect_valid  in   1            flush + restart fetch (branch/jump/trap)
//  redirect_pc     in   ADDR_WIDTH   new PC; bits[1:0] forced to 0
//  id_valid        out  1            queue head valid toward decode
//  id_ready        in   1            decode accepts head
//  id_instr        out  INSTR_WIDTH  head instruction
//  id_pc           out  ADDR_WIDTH   head PC
//  queue_count     out  $clog2(QUEUE_DEPTH+1)  current queue occupancy
// BEHAVIOUR
//  Reset (rst=0): fetch_pc=RESET_VECTOR, rsp_pc=RESET_VECTOR, outstanding=0, drop_cnt=0,
//   queue empty/storage 0, running=0. Outputs: imem_req_valid=0, imem_req_addr=RESET_VECTOR,
//   id_valid=0, id_instr=0, id_pc=0, queue_count=0. running<=1 on first clk edge after release.
//  imem_req_addr = fetch_pc (registered). imem_req_valid = running & !redirect_valid &
//   outstanding<MAX_OUTSTANDING & (outstanding+queue_count)<QUEUE_DEPTH (space reserved per request).
//  Req handshake (valid&ready): fetch_pc<=fetch_pc+4 mod 2^ADDR_WIDTH; outstanding++.
//  Response: outstanding--. If drop_cnt>0: discard, drop_cnt--. Else push {rsp_pc,data},
//   rsp_pc<=rsp_pc+4 (wraps). Push never finds queue full (guaranteed by credit rule).
//  Latency: req accepted cycle N, rsp cycle N+L -> id_valid at N+L+1. No bypass.
//  Decode pop on id_valid&id_ready; push+pop same cycle -> count unchanged.
//  id_valid/id_instr/id_pc hold stable while id_valid & !id_ready (no redirect).
//  Redirect (highest priority, cycle R): no request issued; queue flushed (count 0, id_valid 0
//   from R+1); any pop in R ignored; response arriving in R discarded;
//   fetch_pc,rsp_pc<=redirect_pc&~3; drop_cnt<=outstanding-imem_rsp_valid. First new req at R+1.
//  Redirect while drop_cnt>0: same rule (drop_cnt recomputed from outstanding).
//  Back-to-back redirects: last one wins; each cycle obeys the above.
//  Response with outstanding==0: protocol error; assertion fires, state unchanged.
//  Reset mid-operation: all state cleared asynchronously; memory shares rst, no stale responses.
// STRUCTURE
//  common pkg: INSTR_BYTES=4, PC_ALIGN_MASK, typedef fetch_entry_t {pc,instr}
//   built on PROGRAM_ADDRESS_WIDTH; reuse existing RESET constant.
//  Sub-module fetch_queue: sync FIFO, show-ahead head, push/pop/flush, count output.
//  Top holds fetch_pc, rsp_pc, outstanding, drop_cnt, credit logic, protocol assertions.
// TESTING
//  1 Reset: rst=0 mid-stream -> all outputs at reset values; release -> cycle+1 req_valid=1, addr=0x0.
//  2 Stream: ready=1, L=1, id_ready=1 -> id_pc 0x0,0x4,0x8.. one/cycle, instrs in order, none lost.
//  3 Backpressure: id_ready=0 -> queue_count=4, req_valid=0, exactly 4 accepted; id_ready=1
//    -> drain 0x0..0xC, fetch resumes at 0x10, no dup.
//  4 Redirect with 2 outstanding, redirect_pc=0x100 -> next 2 rsp dropped, queue 0 at R+1,
//    first id_pc=0x100.
//  5 Redirect+rsp+pop same cycle, redirect_pc=0x102 -> rsp discarded, drop_cnt=outstanding-1,
//    next id_pc=0x100.
//  6 Wrap: ADDR_WIDTH=8, RESET_VECTOR=0xF8 -> id_pc 0xF8,0xFC,0x00,0x04.

Source files
------------

// File: rtl/instruction_prefetch_pkg.sv
// Shared fetch-path constants and the decode hand-off entry type.
package instruction_prefetch_pkg;

  localparam int unsigned PROGRAM_ADDRESS_WIDTH = 32;
  localparam int unsigned INSTRUCTION_WIDTH     = 32;
  localparam int unsigned INSTR_BYTES           = 4;

  localparam logic [PROGRAM_ADDRESS_WIDTH-1:0] RESET_PC      = '0;
  localparam logic [PROGRAM_ADDRESS_WIDTH-1:0] PC_ALIGN_MASK =
    ~PROGRAM_ADDRESS_WIDTH'(INSTR_BYTES - 1);

  typedef struct packed {
    logic [PROGRAM_ADDRESS_WIDTH-1:0] pc;
    logic [INSTRUCTION_WIDTH-1:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_prefetch_fetch_queue.sv
// Synchronous show-ahead FIFO holding {pc,instr} entries for decode.
module instruction_prefetch_fetch_queue #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH + 1),
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Next-state for storage, pointers and occupancy; flush wins over push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head is presented straight from storage (show-ahead).
  always_comb begin
    head_valid = (count_q != '0);
    head_data  = mem_q[rd_ptr_q];
    count      = count_q;
  end

endmodule

// File: rtl/instruction_prefetch.sv
// Fetch front-end: in-order imem requests with credit-limited prefetch,
// redirect flush and discard of stale in-flight responses.
module instruction_prefetch
  import instruction_prefetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = PROGRAM_ADDRESS_WIDTH,
  parameter int unsigned INSTR_WIDTH     = INSTRUCTION_WIDTH,
  parameter int unsigned QUEUE_DEPTH     = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(RESET_PC),
  localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [ADDR_WIDTH-1:0]  imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [INSTR_WIDTH-1:0] id_instr,
  output logic [ADDR_WIDTH-1:0]  id_pc,
  output logic [CW-1:0]          queue_count
);

  localparam int unsigned CW1 = CW + 1;
  localparam int unsigned EW  = ADDR_WIDTH + INSTR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(INSTR_BYTES);
  // Built from the low-bit complement so it stays correct for any ADDR_WIDTH.
  localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'(~PC_ALIGN_MASK);

  logic                  running_q, running_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [CW-1:0]         drop_cnt_q, drop_cnt_d;

  logic          credit_ok;
  logic          req_fire;
  logic          rsp_ok;
  logic          q_push;
  logic          q_pop;
  logic          q_flush;
  logic [EW-1:0] q_head;

  // Credit check, request handshake and next-state for PCs and counters.
  always_comb begin
    credit_ok = (outstanding_q < CW'(MAX_OUTSTANDING)) &&
                (({1'b0, outstanding_q} + {1'b0, queue_count}) < CW1'(QUEUE_DEPTH));
    imem_req_valid = running_q && !redirect_valid && credit_ok;
    req_fire       = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp_ok         = imem_rsp_valid && (outstanding_q != '0);

    running_d     = 1'b1;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_ok);
    q_push        = 1'b0;
    q_pop         = 1'b0;
    q_flush       = 1'b0;

    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      q_flush    = 1'b1;
      fetch_pc_d = redirect_pc & ALIGN;
      rsp_pc_d   = redirect_pc & ALIGN;
      drop_cnt_d = outstanding_q - CW'(rsp_ok);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + STEP;
      end
      if (rsp_ok) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - CW'(1);
        end else begin
          q_push   = 1'b1;
          rsp_pc_d = rsp_pc_q + STEP;
        end
      end
      q_pop = id_valid && id_ready;
    end

    imem_req_addr = fetch_pc_q;
  end

  // Fetch-path state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      running_q     <= 1'b0;
      fetch_pc_q    <= RESET_VECTOR;
      rsp_pc_q      <= RESET_VECTOR;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      running_q     <= running_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  instruction_prefetch_fetch_queue #(
    .WIDTH (EW),
    .DEPTH (QUEUE_DEPTH)
  ) u_fetch_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (q_push),
    .push_data  ({rsp_pc_q, imem_rsp_data}),
    .pop        (q_pop),
    .flush      (q_flush),
    .head_valid (id_valid),
    .head_data  (q_head),
    .count      (queue_count)
  );

  // Split the queue head into decode-side fields.
  always_comb begin
    {id_pc, id_instr} = q_head;
  end

  a_rsp_has_outstanding: assert property (@(posedge clk) disable iff (!rst)
    !(imem_rsp_valid && (outstanding_q == '0)));

  a_push_not_full: assert property (@(posedge clk) disable iff (!rst)
    !(q_push && (queue_count == CW'(QUEUE_DEPTH))));

endmodule

// File: tb/tb_instruction_prefetch.sv
// Scoreboard bench: randomized memory/decode/redirect traffic against a
// sequential-stream reference model, plus a small 8-bit wrap instance.
module tb_instruction_prefetch;
  import instruction_prefetch_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned IW = 32;
  localparam int unsigned QD = 4;
  localparam int unsigned MO = 2;
  localparam int unsigned CW = $clog2(QD + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          imem_req_valid, imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid;
  logic [IW-1:0] imem_rsp_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          id_valid, id_ready;
  logic [IW-1:0] id_instr;
  logic [AW-1:0] id_pc;
  logic [CW-1:0] queue_count;

  instruction_prefetch #(
    .ADDR_WIDTH      (AW),
    .INSTR_WIDTH     (IW),
    .QUEUE_DEPTH     (QD),
    .MAX_OUTSTANDING (MO),
    .RESET_VECTOR    (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .queue_count    (queue_count)
  );

  // 8-bit address instance used for the wrap-around case.
  logic          rst_w;
  logic          w_req_valid, w_req_ready;
  logic [7:0]    w_req_addr;
  logic          w_rsp_valid;
  logic [IW-1:0] w_rsp_data;
  logic          w_redirect_valid;
  logic [7:0]    w_redirect_pc;
  logic          w_id_valid, w_id_ready;
  logic [IW-1:0] w_id_instr;
  logic [7:0]    w_id_pc;
  logic [CW-1:0] w_queue_count;

  instruction_prefetch #(
    .ADDR_WIDTH      (8),
    .INSTR_WIDTH     (IW),
    .QUEUE_DEPTH     (4),
    .MAX_OUTSTANDING (2),
    .RESET_VECTOR    (8'hF8)
  ) dut_w (
    .clk            (clk),
    .rst            (rst_w),
    .imem_req_valid (w_req_valid),
    .imem_req_ready (w_req_ready),
    .imem_req_addr  (w_req_addr),
    .imem_rsp_valid (w_rsp_valid),
    .imem_rsp_data  (w_rsp_data),
    .redirect_valid (w_redirect_valid),
    .redirect_pc    (w_redirect_pc),
    .id_valid       (w_id_valid),
    .id_ready       (w_id_ready),
    .id_instr       (w_id_instr),
    .id_pc          (w_id_pc),
    .queue_count    (w_queue_count)
  );

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_data(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Stimulus knobs (percent, redirect in per mille).
  int p_ready   = 100;
  int p_idready = 0;
  int p_redir   = 0;
  int lat_max   = 1;

  // Reference model: decode must see one sequential stream per redirect/reset.
  fetch_entry_t exp_q[$];
  logic [31:0]  next_exp_pc;
  logic [31:0]  exp_fetch;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend[$];

  int cyc       = 0;
  int outst_now = 0;
  int acc_cnt   = 0;
  int pop_cnt   = 0;

  function automatic void new_stream(logic [31:0] pc);
    exp_q.delete();
    next_exp_pc = pc;
    exp_fetch   = pc;
  endfunction

  function automatic void refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{pc: next_exp_pc, instr: mem_data(next_exp_pc)});
      next_exp_pc = next_exp_pc + 32'd4;
    end
  endfunction

  // Stimulus + memory model: drives inputs at negedge, records accepted requests.
  initial begin
    int lat;
    int due;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        pend.delete();
        outst_now = 0;
        acc_cnt   = 0;
        new_stream(32'h0);
        refill();
      end else begin
        outst_now      = pend.size();
        imem_req_ready = ($urandom_range(99) < p_ready);
        id_ready       = ($urandom_range(99) < p_idready);
        redirect_valid = ($urandom_range(999) < p_redir);
        if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
        else                        redirect_pc = $urandom() & 32'h3FF;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_data(pend[0].addr);
          void'(pend.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
          imem_rsp_data  = $urandom();
        end
        if (redirect_valid) new_stream(redirect_pc & ~32'h3);
        refill();
        #1;
        if (imem_req_valid && imem_req_ready) begin
          check("req_addr", imem_req_addr, exp_fetch);
          exp_fetch = exp_fetch + 32'd4;
          lat = $urandom_range(lat_max, 1);
          due = cyc + lat;
          if (pend.size() > 0 && pend[$].due >= due) due = pend[$].due + 1;
          pend.push_back('{addr: imem_req_addr, due: due});
          acc_cnt++;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every decode hand-off.
  initial begin
    logic        hold_prev;
    logic        redir_prev;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    fetch_entry_t e;
    hold_prev  = 1'b0;
    redir_prev = 1'b0;
    prev_pc    = '0;
    prev_instr = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        hold_prev  = 1'b0;
        redir_prev = 1'b0;
        continue;
      end
      if (imem_req_valid)
        check("credit", (outst_now < MO) && (outst_now + int'(queue_count) < QD), 1);
      if (redir_prev) begin
        check("flush_count", queue_count, 0);
        check("flush_valid", id_valid, 0);
      end
      if (hold_prev) begin
        check("hold_valid", id_valid, 1);
        check("hold_pc", id_pc, prev_pc);
        check("hold_instr", id_instr, prev_instr);
      end
      if (id_valid && id_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          check("sb_nonempty", 0, 1);
        end else begin
          e = exp_q.pop_front();
          check("id_pc", id_pc, e.pc);
          check("id_instr", id_instr, e.instr);
        end
        pop_cnt++;
      end
      hold_prev  = id_valid && !id_ready && !redirect_valid;
      redir_prev = redirect_valid;
      prev_pc    = id_pc;
      prev_instr = id_instr;
    end
  end

  // Wrap instance: always-ready memory with latency 1, decode always ready.
  logic [7:0] wq[$];
  int  w_seen = 0;
  logic w_done = 1'b0;

  initial begin
    logic       pend_v;
    logic [7:0] pend_a;
    rst_w = 1'b0;
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_rsp_data  = '0;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = '0;
    w_id_ready  = 1'b0;
    pend_v = 1'b0;
    pend_a = '0;
    repeat (2) @(posedge clk);
    #2 rst_w = 1'b1;
    wq.push_back(8'hF8);
    wq.push_back(8'hFC);
    wq.push_back(8'h00);
    wq.push_back(8'h04);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      w_rsp_valid = pend_v;
      w_rsp_data  = mem_data({24'h0, pend_a});
      w_req_ready = 1'b1;
      w_id_ready  = 1'b1;
      #1;
      pend_v = w_req_valid && w_req_ready;
      pend_a = w_req_addr;
    end
    w_done = 1'b1;
  end

  initial begin
    logic [7:0] ep;
    for (int c = 0; c < 44; c++) begin
      @(negedge clk);
      #2;
      if (rst_w && w_id_valid && w_id_ready && wq.size() > 0) begin
        ep = wq.pop_front();
        check("wrap_pc", w_id_pc, ep);
        check("wrap_instr", w_id_instr, mem_data({24'h0, ep}));
        w_seen++;
      end
    end
    check("wrap_seen", w_seen, 4);
  end

  // Phase sequencing.
  initial begin
    int p0;
    rst = 1'b0;
    p_ready = 100; p_idready = 0; lat_max = 1; p_redir = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk); #2;
    check("rel_valid0", imem_req_valid, 0);
    @(negedge clk); #2;
    check("rel_valid", imem_req_valid, 1);
    check("rel_addr", imem_req_addr, 32'h0);

    // Backpressure: exactly QD requests accepted, then fetch stalls.
    repeat (20) @(negedge clk);
    #2;
    check("bp_count", queue_count, QD);
    check("bp_req_valid", imem_req_valid, 0);
    check("bp_accepted", acc_cnt, QD);

    // Full-rate stream.
    p_idready = 100;
    p0 = pop_cnt;
    repeat (40) @(negedge clk);
    check("stream_rate", (pop_cnt - p0) >= 36, 1);

    // Random traffic with redirects.
    p_ready = 70; p_idready = 70; lat_max = 4; p_redir = 40;
    repeat (3000) @(negedge clk);
    // Dense redirects: back-to-back and coinciding with responses/pops.
    p_ready = 100; p_idready = 100; lat_max = 1; p_redir = 200;
    repeat (600) @(negedge clk);

    // Reset mid-stream.
    p_ready = 90; p_idready = 80; lat_max = 3; p_redir = 0;
    repeat (30) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_id_valid", id_valid, 0);
    check("rst_id_instr", id_instr, 0);
    check("rst_id_pc", id_pc, 0);
    check("rst_count", queue_count, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk); #2;
    check("rel2_valid0", imem_req_valid, 0);
    @(negedge clk); #2;
    check("rel2_valid", imem_req_valid, 1);
    check("rel2_addr", imem_req_addr, 32'h0);

    p_ready = 70; p_idready = 70; lat_max = 4; p_redir = 40;
    repeat (1500) @(negedge clk);
    check("wrap_done", w_done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
